// File: rtl/r_bram_stream.sv
// Read-side sequencer for a 512-deep BRAM: issues port-B reads while words are
// available, captures read data after RD_LAT cycles, and streams it through a 4-entry buffer.
module r_bram_stream #(
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              CLK,
   input  logic              rst_n,
   input  logic              wr_push,
   input  logic [DATA_W-1:0] DOUT_B,
   output logic              r_bram_addr_en,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic [9:0]        rd_avail,
   output logic              ovf_err
);

   localparam logic [9:0] DEPTH = 10'd512;

   logic [9:0]        avail;
   logic [RD_LAT-1:0] inflight;
   logic [2:0]        occ;
   logic [1:0]        rd_ptr;
   logic [1:0]        wr_ptr;
   logic [DATA_W-1:0] buffer [4];
   logic [2:0]        flight_cnt;
   logic              capture;
   logic              pop;

   always_comb begin
      // NOTE: assign a default before the loop so no path leaves flight_cnt unassigned (no latch).
      flight_cnt = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         flight_cnt = flight_cnt + {2'b00, inflight[i]};
      end
   end

   // Reads in flight reserve buffer slots, so a capture always finds room.
   assign r_bram_addr_en = (avail != '0) && ((occ + flight_cnt) < 3'd4);
   assign capture        = inflight[RD_LAT-1];
   assign m_valid        = (occ != '0);
   assign pop            = m_valid && m_ready;
   assign m_data         = buffer[rd_ptr];
   assign rd_avail       = avail;

   if (RD_LAT == 1) begin : g_lat1
      always_ff @(posedge CLK or negedge rst_n) begin
         if (!rst_n) inflight <= '0;
         else        inflight <= r_bram_addr_en;
      end
   end else begin : g_latn
      always_ff @(posedge CLK or negedge rst_n) begin
         if (!rst_n) inflight <= '0;
         else        inflight <= {inflight[RD_LAT-2:0], r_bram_addr_en};
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         avail   <= '0;
         ovf_err <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register sees pre-edge values.
         case ({wr_push, r_bram_addr_en})
            2'b10: begin
               if (avail == DEPTH) ovf_err <= 1'b1;
               else                avail   <= avail + 10'd1;
            end
            2'b01:   avail <= avail - 10'd1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         occ    <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         // NOTE: this small buffer is reset (unlike a RAM) so m_data is 0 and never stale after reset.
         for (int i = 0; i < 4; i++) buffer[i] <= '0;
      end else begin
         if (capture) begin
            buffer[wr_ptr] <= DOUT_B;
            wr_ptr         <= wr_ptr + 2'd1;
         end
         if (pop) rd_ptr <= rd_ptr + 2'd1;
         case ({capture, pop})
            2'b10:   occ <= occ + 3'd1;
            2'b01:   occ <= occ - 3'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/r_bram_stream.md
Name: r_bram_stream

Overview:
- Read-side sequencer directly downstream of the BRAM port-B read address counter.
- Tracks how many words the write side has deposited in the 512-deep BRAM.
- Drives the address counter's advance enable (r_bram_addr_en) and captures port-B read data after the BRAM read latency.
- Presents the captured words on a valid/ready output stream through a 4-entry output buffer, so backpressure never loses a word already in flight.

Parameters:
- DATA_W, 32, width of BRAM port-B read data and output stream data.
- RD_LAT, 1, BRAM port-B read latency in cycles; legal values 1 or 2.

Ports:
- CLK  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset; assertion clears all state immediately; deassertion is synchronised externally.
- wr_push  input  1  one-cycle pulse per word written into the BRAM by the write side.
- DOUT_B  input  DATA_W  BRAM port-B read data.
- r_bram_addr_en  output  1  advance enable to the port-B address counter; high means the word at the current ADDR_B is being read this cycle.
- m_valid  output  1  output stream word valid.
- m_ready  input  1  downstream accepts word.
- m_data  output  DATA_W  output stream data, the head of the output buffer.
- rd_avail  output  10  count of words written but not yet read from the BRAM, range 0..512.
- ovf_err  output  1  sticky flag: a push arrived while rd_avail was 512.

Behaviour:
- Reset values: r_bram_addr_en=0, m_valid=0, m_data=0, rd_avail=0, ovf_err=0, in-flight pipe cleared, buffer empty.
- State:
  - avail: 10-bit count, driven out as rd_avail.
  - inflight: RD_LAT-bit shift register of issued reads.
  - occ: 3-bit buffer occupancy, 0..4.
  - 4-entry circular buffer with 2-bit read and write pointers.
- Issue rule, combinational from registered state: r_bram_addr_en = (avail != 0) && (occ + popcount(inflight) < 4). No pop credit is taken in the same cycle.
- inflight shifts every cycle; bit 0 is loaded with r_bram_addr_en.
- Capture: when the bit leaving inflight is 1, DOUT_B is written into the buffer at the write pointer on that edge. This is exactly RD_LAT edges after the edge that sampled r_bram_addr_en=1.
- Latency: a wr_push sampled at edge E0 with the pipe idle gives:
  - r_bram_addr_en=1 during the cycle after E0;
  - m_valid=1 after edge E0+1+RD_LAT.
- Throughput: with m_ready held high, one word per cycle is sustained indefinitely for both RD_LAT values.
- Output:
  - m_valid = (occ != 0); m_data = buffer[read pointer].
  - A pop occurs when m_valid && m_ready; it advances the read pointer.
  - While m_valid && !m_ready, m_data and m_valid are held stable.
- avail update per edge: +1 on wr_push, -1 on issue.
  - Push and issue on the same edge: avail unchanged.
  - Push while avail==512 with no simultaneous issue: avail stays 512 and ovf_err is set.
  - If an issue occurs on the same edge as such a push, the push is counted and ovf_err is not set.
- ovf_err clears only on reset.
- occ update per edge: +1 on capture, -1 on pop. Capture and pop on the same edge: occ unchanged. Capture never occurs when occ==4, guaranteed by the issue rule.
- Address wrap: 511 to 0 is handled entirely by the address counter. This block issues one enable per word regardless of address value.
- Reset mid-operation: in-flight reads are discarded, the buffer is emptied and avail goes to 0. The address counter must be reset concurrently by the same reset event.
- rd_avail counts unread BRAM words only; words already issued but not yet popped are excluded.

Test Plan:
- Reset: rst_n low with wr_push toggling -> all outputs 0; r_bram_addr_en never high during reset.
- Single word, RD_LAT=1: one wr_push at edge 0, m_ready=1, DOUT_B=0xA5A5_0001 in the capture cycle -> r_bram_addr_en high for exactly cycle 1; m_valid high after edge 2 with m_data=0xA5A5_0001 for one cycle; rd_avail returns 0.
- Full wrap burst: 512 back-to-back pushes, then 4 more words pushed after reads start, m_ready=1, both RD_LAT values:
  - 516 enables with no bubbles after the first;
  - output sequence matches BRAM contents, including addresses 511 then 0;
  - ovf_err stays 0.
- Backpressure: 10 words available, m_ready=0 -> exactly 4 enables issued, then r_bram_addr_en low; m_valid and m_data stable; rd_avail=6. Releasing m_ready drains all 10 words in order.
- Overflow: 512 pushes with no reads permitted (m_ready=0 and buffer full), then one more push -> rd_avail stays 512 and ovf_err=1. Issuing a read while pushing on the same edge -> rd_avail unchanged.
- Async reset mid-stream: rst_n pulsed low between clock edges with 2 reads in flight and 3 words buffered -> outputs clear immediately without waiting for a clock edge; no stale word appears on m_data after release.
